// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control unit: sequences fetch/decode/execute/memory/writeback.
// Define MC_FSM_MEMWAIT_EN to enable the mem_ready wait-state handshake.
module mc_control_fsm #(
    parameter int OPW     = 3,
    parameter int FUNCW   = 4,
    parameter int ALUCTW  = 3,
    parameter int ALU_ADD = 0,
    parameter int ALU_SUB = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [FUNCW-1:0]  func,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              MemtoReg,
    output logic              Immsel,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic              PCsrc,
    output logic              PCWrite,
    output logic [1:0]        ALUsrcB,
    output logic [ALUCTW-1:0] alu_op,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_HALT    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    typedef struct packed {
        logic              iord;
        logic              memwrite;
        logic              memtoreg;
        logic              immsel;
        logic              regwrite;
        logic              alusrca;
        logic              pcsrc;
        logic              halted;
        logic              illegal;
        logic [1:0]        alusrcb;
        logic [ALUCTW-1:0] alu_op;
    } ctrl_t;

    localparam logic [ALUCTW-1:0] L_ADD = ALUCTW'(ALU_ADD);
    localparam logic [ALUCTW-1:0] L_SUB = ALUCTW'(ALU_SUB);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_mem_ok;
    logic   w_fetch_go;
    logic   w_br_take;
    logic   w_unused;

`ifdef MC_FSM_MEMWAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    assign w_unused = &{1'b0, func, mem_ready};

    // Moore control set for a state; opcode/func are held stable by the IR for the whole instruction.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [OPW-1:0] op,
                                       input logic [FUNCW-1:0] fn);
        ctrl_t c;
        c        = '0;
        c.alu_op = L_ADD;
        case (s)
            S_FETCH:   c.alusrcb = 2'b01;
            S_DECODE:  begin c.immsel = 1'b1; c.alusrcb = 2'b10; end
            S_MEMADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.immsel  = (op == OPW'(4));
            end
            S_MEMRD:   begin c.iord = 1'b1; c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:   begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                c.immsel   = 1'b1;
                c.alusrca  = 1'b1;
                c.alusrcb  = 2'b10;
            end
            S_EXEC:    begin c.alusrca = 1'b1; c.alu_op = fn[ALUCTW-1:0]; end
            S_ALUWB:   begin c.regwrite = 1'b1; c.alu_op = fn[ALUCTW-1:0]; end
            S_BRANCH:  begin
                c.alusrca = 1'b1;
                c.alu_op  = L_SUB;
                c.pcsrc   = 1'b1;
                c.immsel  = 1'b1;
            end
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_HALT:    c.halted = 1'b1;
            S_TRAP:    c.illegal = 1'b1;
            default:   c.alu_op = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OPW'(1))                           w_next = S_EXEC;
                else if (opcode == OPW'(2))                      w_next = S_ADDIEX;
                else if (opcode == OPW'(3) || opcode == OPW'(4)) w_next = S_MEMADDR;
                else if (opcode == OPW'(5))                      w_next = S_BRANCH;
                else if (opcode == OPW'(6))                      w_next = S_HALT;
                else                                             w_next = S_TRAP;
            end
            S_MEMADDR: w_next = (opcode == OPW'(3)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_HALT:    w_next = S_HALT;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_FETCH;
        endcase
    end

    // Controls are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH, opcode, func);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, opcode, func);
        end
    end

    // BEQ takes on zero, BNE (func[0]=1) on not-zero.
    assign w_fetch_go = (r_state == S_FETCH) & w_mem_ok;
    assign w_br_take  = (r_state == S_BRANCH) & (zero ^ func[0]);

    assign IRWrite  = w_fetch_go;
    assign PCWrite  = w_fetch_go | w_br_take;
    assign IorD     = r_ctrl.iord;
    assign MemWrite = r_ctrl.memwrite;
    assign MemtoReg = r_ctrl.memtoreg;
    assign Immsel   = r_ctrl.immsel;
    assign RegWrite = r_ctrl.regwrite;
    assign ALUSrcA  = r_ctrl.alusrca;
    assign PCsrc    = r_ctrl.pcsrc;
    assign ALUsrcB  = r_ctrl.alusrcb;
    assign alu_op   = r_ctrl.alu_op;
    assign halted   = r_ctrl.halted;
    assign illegal  = r_ctrl.illegal;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus random instruction stream
// checked every cycle against an instruction-level model.
module tb_mc_control_fsm;

    localparam int OPW    = 4;
    localparam int FUNCW  = 5;
    localparam int ALUCTW = 3;
`ifdef MC_FSM_MEMWAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [OPW-1:0]    opcode = '0;
    logic [FUNCW-1:0]  func = '0;
    logic              zero = 1'b0;
    logic              mem_ready = 1'b1;
    logic              IorD, MemWrite, IRWrite, MemtoReg, Immsel, RegWrite, ALUSrcA, PCsrc, PCWrite;
    logic [1:0]        ALUsrcB;
    logic [ALUCTW-1:0] alu_op;
    logic              halted, illegal;
    logic [3:0]        state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mc_control_fsm #(.OPW(OPW), .FUNCW(FUNCW), .ALUCTW(ALUCTW), .ALU_ADD(0), .ALU_SUB(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .Immsel(Immsel), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCsrc(PCsrc), .PCWrite(PCWrite), .ALUsrcB(ALUsrcB), .alu_op(alu_op),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit mok(input bit mr);
        return WAIT_EN ? mr : 1'b1;
    endfunction

    // Instruction-level model: the remaining phase list of the current instruction.
    int m_st = 0;
    int m_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0;
            m_q.delete();
        end else if (m_st == 0) begin
            if (mok(mem_ready)) begin
                case (int'(opcode))
                    1:       m_q = '{1, 6, 7};
                    2:       m_q = '{1, 9, 10};
                    3:       m_q = '{1, 2, 3, 4};
                    4:       m_q = '{1, 2, 5};
                    5:       m_q = '{1, 8};
                    6:       m_q = '{1, 11};
                    default: m_q = '{1, 12};
                endcase
                m_st = m_q.pop_front();
            end
        end else if (m_st == 11 || m_st == 12) begin
            m_st = m_st;
        end else if ((m_st == 3 || m_st == 5) && !mok(mem_ready)) begin
            m_st = m_st;
        end else if (m_q.size() > 0) begin
            m_st = m_q.pop_front();
        end else begin
            m_st = 0;
        end
    end

    // {IorD,MemWrite,IRWrite,MemtoReg,Immsel,RegWrite,ALUSrcA,PCsrc,PCWrite,ALUsrcB,alu_op,halted,illegal,state}
    function automatic logic [19:0] expect_out(input int st, input int op, input int fn,
                                               input bit z, input bit mr);
        bit iord = 0, mw = 0, irw = 0, m2r = 0, imm = 0, rw = 0, asa = 0, pcs = 0, pcw = 0;
        bit hlt = 0, ill = 0;
        int bsel = 0;
        int alu = 0;
        case (st)
            0:  begin irw = mok(mr); pcw = mok(mr); bsel = 1; end
            1:  begin imm = 1; bsel = 2; end
            2:  begin asa = 1; bsel = 2; imm = (op == 4); end
            3:  begin iord = 1; asa = 1; bsel = 2; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; imm = 1; asa = 1; bsel = 2; end
            6:  begin asa = 1; alu = fn % 8; end
            7:  begin rw = 1; alu = fn % 8; end
            8:  begin asa = 1; alu = 1; pcs = 1; imm = 1; pcw = (fn % 2 == 0) ? z : !z; end
            9:  begin asa = 1; bsel = 2; end
            10: rw = 1;
            11: hlt = 1;
            12: ill = 1;
            default: ;
        endcase
        return {iord, mw, irw, m2r, imm, rw, asa, pcs, pcw, 2'(bsel), 3'(alu), hlt, ill, 4'(st)};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [19:0] act;
            logic [19:0] exp_v;
            act = {IorD, MemWrite, IRWrite, MemtoReg, Immsel, RegWrite, ALUSrcA, PCsrc, PCWrite,
                   ALUsrcB, alu_op, halted, illegal, state};
            exp_v = expect_out(m_st, int'(opcode), int'(func), zero, mem_ready);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t model_state=%0d actual=%05h required=%05h",
                         $time, m_st, act, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
        end
    endtask

    int exp_q[$];
    int mr_q[$];
    int cap_alu[64], cap_rw[64], cap_m2r[64], cap_mw[64], cap_pcw[64], cap_hlt[64], cap_ill[64];

    // Entered at a negedge while in FETCH; exp_q lists the states after each following edge.
    task automatic run_seq(input string nm);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            if (k < mr_q.size()) mem_ready = mr_q[k][0];
            @(negedge clk);
            cap_alu[k] = int'(alu_op);
            cap_rw[k]  = int'(RegWrite);
            cap_m2r[k] = int'(MemtoReg);
            cap_mw[k]  = int'(MemWrite);
            cap_pcw[k] = int'(PCWrite);
            cap_hlt[k] = int'(halted);
            cap_ill[k] = int'(illegal);
            chk($sformatf("%s_state%0d", nm, k), 32'(state), 32'(exp_q[k]));
        end
    endtask

    task automatic start(input int op, input int fn, input bit mr, input bit z);
        #1;
        opcode    = OPW'(op);
        func      = FUNCW'(fn);
        mem_ready = mr;
        zero      = z;
    endtask

    task automatic do_reset(input string nm);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_state"}, 32'(state), 32'd0);
        chk({nm, "_irwrite"}, 32'(IRWrite), 32'd1);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
        chk({nm, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        int stuck = 0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd1);
        chk("rst_pcwrite", 32'(PCWrite), 32'd1);
        chk("rst_alusrcb", 32'(ALUsrcB), 32'd1);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);

        // R-type: func upper bits must not leak into alu_op
        start(1, 5'b01011, 1'b1, 1'b0);
        exp_q = '{1, 6, 7, 0}; mr_q = '{1, 1, 1, 1};
        run_seq("rtype");
        chk("rtype_alu_exec", 32'(cap_alu[1]), 32'd3);
        chk("rtype_alu_wb", 32'(cap_alu[2]), 32'd3);
        for (int k = 0; k < 4; k++) chk($sformatf("rtype_rw%0d", k), 32'(cap_rw[k]), 32'(k == 2));

        start(2, 0, 1'b1, 1'b0);
        exp_q = '{1, 9, 10, 0}; mr_q = '{1, 1, 1, 1};
        run_seq("addi");

        start(3, 0, 1'b1, 1'b0);
`ifdef MC_FSM_MEMWAIT_EN
        exp_q = '{1, 2, 3, 3, 3, 4, 0}; mr_q = '{1, 1, 0, 0, 1, 1, 1};
        run_seq("lw_wait");
        for (int k = 0; k < 7; k++) chk($sformatf("lw_m2r%0d", k), 32'(cap_m2r[k]), 32'(k == 5));
`else
        exp_q = '{1, 2, 3, 4, 0}; mr_q = '{1, 1, 0, 1, 1};
        run_seq("lw");
        for (int k = 0; k < 5; k++) chk($sformatf("lw_m2r%0d", k), 32'(cap_m2r[k]), 32'(k == 3));
`endif

`ifdef MC_FSM_MEMWAIT_EN
        start(4, 0, 1'b1, 1'b0);
        exp_q = '{1, 2, 5, 5, 0}; mr_q = '{1, 1, 0, 1, 1};
        run_seq("sw_wait");
        for (int k = 0; k < 5; k++) chk($sformatf("sw_mw%0d", k), 32'(cap_mw[k]), 32'(k == 2 || k == 3));
        start(2, 0, 1'b0, 1'b0);
        #1;
        chk("fetchwait_irwrite", 32'(IRWrite), 32'd0);
        chk("fetchwait_pcwrite", 32'(PCWrite), 32'd0);
        exp_q = '{0, 1, 9, 10, 0}; mr_q = '{1, 1, 1, 1, 1};
        run_seq("fetchwait");
`else
        start(4, 0, 1'b0, 1'b0);
        exp_q = '{1, 2, 5, 0}; mr_q = '{0, 0, 0, 0};
        run_seq("sw_nowait");
        for (int k = 0; k < 4; k++) chk($sformatf("sw_mw%0d", k), 32'(cap_mw[k]), 32'(k == 2));
        #1;
        chk("fetch_irwrite_const", 32'(IRWrite), 32'd1);
        mem_ready = 1'b1;
`endif

        start(5, 0, 1'b1, 1'b1);
        exp_q = '{1, 8, 0}; mr_q = '{1, 1, 1};
        run_seq("beq");
        chk("beq_pcwrite", 32'(cap_pcw[1]), 32'd1);
        chk("beq_aluop", 32'(cap_alu[1]), 32'd1);
        start(5, 1, 1'b1, 1'b1);
        run_seq("bne_z1");
        chk("bne_z1_pcwrite", 32'(cap_pcw[1]), 32'd0);
        chk("bne_aluop", 32'(cap_alu[1]), 32'd1);
        start(5, 1, 1'b1, 1'b0);
        run_seq("bne_z0");
        chk("bne_z0_pcwrite", 32'(cap_pcw[1]), 32'd1);

        start(3, 0, 1'b1, 1'b0);
        exp_q = '{1, 2, 3}; mr_q = '{1, 1, 0};
        run_seq("lw_mid");
        do_reset("rst_midlw");

        start(6, 0, 1'b1, 1'b0);
        exp_q = '{1, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11};
        mr_q  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_seq("halt");
        for (int k = 1; k < 12; k++) chk($sformatf("halt_h%0d", k), 32'(cap_hlt[k]), 32'd1);
        do_reset("rst_halt");

        start(7, 0, 1'b1, 1'b0);
        exp_q = '{1, 12, 12, 12}; mr_q = '{1, 1, 1, 1};
        run_seq("trap7");
        chk("trap7_illegal", 32'(cap_ill[2]), 32'd1);
        do_reset("rst_trap7");
        start(9, 0, 1'b1, 1'b0);
        exp_q = '{1, 12}; mr_q = '{1, 1};
        run_seq("trap9");
        do_reset("rst_trap9");
        start(0, 0, 1'b1, 1'b0);
        run_seq("trap0");
        do_reset("rst_trap0");

        // Random instruction stream; opcode/func only change while the model is in FETCH
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            zero      = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 7);
            if (m_st == 11 || m_st == 12) stuck++;
            else stuck = 0;
            if (reset) reset = 1'b0;
            else if (stuck > 6 || $urandom_range(0, 299) == 0) reset = 1'b1;
            if (m_st == 0) begin
                if ($urandom_range(0, 99) < 85) opcode = OPW'($urandom_range(1, 5));
                else opcode = OPW'($urandom_range(0, 15));
                func = FUNCW'($urandom);
            end
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multi-cycle control unit for the processor datapath, the next generation of the fixed 3-bit-opcode control FSM. It sequences fetch/decode/execute/memory/writeback and drives all datapath mux selects and write enables. It adds:
- Configurable opcode, func and ALU-control widths.
- Memory wait-state handshake.
- Internally resolved BEQ/BNE branching.
- A defined HALT state and an illegal-opcode TRAP state.

## Interface
Parameters:
- OPW, 3, opcode width (≥3)
- FUNCW, 4, func field width
- ALUCTW, 3, ALU control width (≤FUNCW)
- ALU_ADD, 0, alu_op code for add
- ALU_SUB, 1, alu_op code for subtract

Ports (one clock; reset is synchronous and active-high; clock port `clk`, reset port `reset`):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- opcode  in  OPW  instruction opcode from IR
- func  in  FUNCW  instruction func field from IR
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes access this cycle
- IorD, MemWrite, IRWrite, MemtoReg, Immsel, RegWrite, ALUSrcA, PCsrc, PCWrite  out  1  datapath controls
- ALUsrcB  out  2  ALU B select: 00 reg, 01 const 1, 10 imm
- alu_op  out  ALUCTW  ALU operation
- halted  out  1  FSM is in HALT
- illegal  out  1  FSM is in TRAP
- state  out  4  current state (debug)

## Operation
- States, with 4-bit encoding:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, HALT=11, TRAP=12
  - Codes 13–15 go to FETCH with all controls 0.
- Opcode decode in DECODE, zero-extended compare:
  - 1 → EXEC
  - 2 → ADDIEX
  - 3, 4 → MEMADDR
  - 5 → BRANCH
  - 6 → HALT
  - any other value → TRAP
- MEMADDR → MEMRD for opcode 3, MEMWR for opcode 4.
- MEMRD → MEMWB → FETCH. MEMWR → FETCH.
- EXEC → ALUWB → FETCH. ADDIEX → ADDIWB → FETCH. BRANCH → FETCH.
- HALT and TRAP hold until reset.
- Per-state controls. Unlisted controls are 0; alu_op = ALU_ADD unless stated.
  - FETCH: IRWrite=PCWrite=mem_ready, ALUsrcB=01.
  - DECODE: Immsel=1, ALUsrcB=10.
  - MEMADDR: ALUSrcA=1, ALUsrcB=10, Immsel=(opcode==4).
  - MEMRD: IorD=1, ALUSrcA=1, ALUsrcB=10.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1, Immsel=1, ALUSrcA=1, ALUsrcB=10.
  - EXEC: ALUSrcA=1, ALUsrcB=00, alu_op=func[ALUCTW-1:0].
  - ALUWB: RegWrite=1, alu_op=func[ALUCTW-1:0].
  - BRANCH: ALUSrcA=1, ALUsrcB=00, alu_op=ALU_SUB, PCsrc=1, Immsel=1.
    - PCWrite=zero when func[0]=0 (BEQ).
    - PCWrite=~zero when func[0]=1 (BNE).
  - ADDIEX: ALUSrcA=1, ALUsrcB=10.
  - ADDIWB: RegWrite=1.
  - HALT: halted=1. TRAP: illegal=1.
- Wait states (with the macro enabled):
  - FETCH, MEMRD and MEMWR advance only when mem_ready=1; otherwise the FSM stays in the same state.
  - While MEMWR waits, MemWrite stays asserted.
  - While FETCH waits, IRWrite and PCWrite are 0.

## Timing
- Controls are Moore outputs from the state register. The exceptions are FETCH's IRWrite/PCWrite (gated by mem_ready) and BRANCH's PCWrite (uses zero); these are same-cycle combinational.
- The rising edge with reset=1 sets state=FETCH, regardless of current state, including HALT, TRAP and mid-wait.
- Post-reset output values:
  - IRWrite=PCWrite=mem_ready, ALUsrcB=01, alu_op=ALU_ADD.
  - All other outputs 0, including halted and illegal.
  - state=0.
- Latency in cycles, FETCH through last state, with zero wait:
  - R-type 4, ADDI 4, LW 5, SW 4, BR 3.
- Each mem_ready=0 cycle in a memory state adds exactly 1 cycle.
- opcode and func must be stable from DECODE through the last state of the instruction (IR is held because IRWrite=0).

## Configuration
- MC_FSM_MEMWAIT_EN.
  - Defined: mem_ready handshake as described above.
  - Undefined: mem_ready is ignored and treated as 1. Memory states always last one cycle, and the FETCH IRWrite/PCWrite controls are constant 1.

## Test plan
- Reset mid-LW, in MEMRD, with mem_ready=0: assert reset for 1 cycle → state=0, IRWrite=1 when mem_ready=1, halted=illegal=0.
- Opcode 1, func=3, mem_ready=1: state sequence 0,1,6,7,0; alu_op=3 in EXEC/ALUWB; RegWrite=1 only in ALUWB.
- Opcode 3 (LW), macro on, mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; MemtoReg=RegWrite=1 only in state 4.
- Opcode 5: with func[0]=0, zero=1 → PCWrite=1 in BRANCH; with func[0]=1, zero=1 → PCWrite=0; alu_op=ALU_SUB in both cases.
- Opcode 6 → halted=1 for 10+ cycles with state=11. Opcode 7 → illegal=1, state=12. Reset clears both.
- Macro undefined, mem_ready held 0 on SW: sequence 0,1,2,5,0 with MemWrite=1 for exactly one cycle.
